// File: rtl/sht40_measure_sequencer.sv
// Drives an I2C master through one SHT40 measurement: write the command, wait for conversion, read 6 bytes, CRC-check.
// Outputs are registered; done fires one cycle after the master returns idle after the read; start is ignored while busy.
module sht40_measure_sequencer #(
  parameter logic [6:0]  DEV_ADDR         = 7'h44,
  parameter logic [7:0]  MEAS_CMD         = 8'hFD,
  parameter logic [19:0] MEAS_WAIT_CYCLES = 20'd170000,
  parameter logic [19:0] TIMEOUT_CYCLES   = 20'd100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        crc_err,
  output logic        timeout_err,
  output logic [15:0] temp_raw,
  output logic [15:0] rh_raw,
  output logic        proc_ready,
  output logic [6:0]  periph_addr,
  output logic [7:0]  cmd_frame,
  output logic        r_or_w,
  output logic        i2c_writes,
  output logic [3:0]  sht_reads,
  output logic        crc_error_out,
  input  logic [2:0]  master_state,
  input  logic        rx_strobe,
  input  logic [7:0]  rx_data
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_WAIT, CONV, RD_REQ, RD_WAIT, FINISH} state_t;

  state_t      state_q, state_d;
  logic        busy_q, busy_d, done_q, done_d, crc_err_q, crc_err_d;
  logic        timeout_err_q, timeout_err_d, proc_ready_q, proc_ready_d;
  logic        r_or_w_q, r_or_w_d, crc_error_out_q, crc_error_out_d;
  logic [15:0] temp_raw_q, temp_raw_d, rh_raw_q, rh_raw_d;
  logic [15:0] temp_buf_q, temp_buf_d, rh_buf_q, rh_buf_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  crc_q, crc_d;
  logic [19:0] dly_q, dly_d, tmo_q, tmo_d;
  logic        timed;

  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) begin
      r = {r[6:0], 1'b0} ^ (r[7] ? 8'h31 : 8'h00);
    end
    return r;
  endfunction

  always_comb begin
    state_d         = state_q;
    busy_d          = busy_q;
    done_d          = 1'b0;
    crc_err_d       = crc_err_q;
    timeout_err_d   = timeout_err_q;
    proc_ready_d    = proc_ready_q;
    r_or_w_d        = r_or_w_q;
    crc_error_out_d = 1'b0;
    temp_raw_d      = temp_raw_q;
    rh_raw_d        = rh_raw_q;
    temp_buf_d      = temp_buf_q;
    rh_buf_d        = rh_buf_q;
    idx_d           = idx_q;
    crc_d           = crc_q;
    dly_d           = dly_q;
    case (state_q)
      IDLE, FINISH: begin
        state_d = IDLE;
        if (start) begin
          crc_err_d     = 1'b0;
          timeout_err_d = 1'b0;
          busy_d        = 1'b1;
          r_or_w_d      = 1'b1;
          proc_ready_d  = 1'b1;
          state_d       = WR_REQ;
        end
      end
      WR_REQ: if (master_state != 3'b000) begin
        proc_ready_d = 1'b0;
        state_d      = WR_WAIT;
      end
      WR_WAIT: if (master_state == 3'b000) begin
        dly_d   = '0;
        state_d = CONV;
      end
      CONV: begin
        if (dly_q == MEAS_WAIT_CYCLES - 20'd1) begin
          r_or_w_d     = 1'b0;
          proc_ready_d = 1'b1;
          idx_d        = '0;
          state_d      = RD_REQ;
        end else begin
          dly_d = dly_q + 20'd1;
        end
      end
      RD_REQ: if (master_state != 3'b000) begin
        proc_ready_d = 1'b0;
        state_d      = RD_WAIT;
      end
      RD_WAIT: begin
        // Bytes 2 and 5 are checked against the CRC of the two bytes before them.
        if (rx_strobe && idx_q < 3'd6 && !crc_err_q) begin
          idx_d = idx_q + 3'd1;
          case (idx_q)
            3'd0: begin temp_buf_d[15:8] = rx_data; crc_d = crc8_step(8'hFF, rx_data); end
            3'd1: begin temp_buf_d[7:0]  = rx_data; crc_d = crc8_step(crc_q, rx_data); end
            3'd3: begin rh_buf_d[15:8]   = rx_data; crc_d = crc8_step(8'hFF, rx_data); end
            3'd4: begin rh_buf_d[7:0]    = rx_data; crc_d = crc8_step(crc_q, rx_data); end
            default: if (rx_data != crc_q) begin
              crc_err_d       = 1'b1;
              crc_error_out_d = 1'b1;
            end
          endcase
        end
        if (master_state == 3'b000) begin
          busy_d  = 1'b0;
          state_d = FINISH;
          if (!crc_err_d) begin
            if (idx_d == 3'd6) begin
              temp_raw_d = temp_buf_q;
              rh_raw_d   = rh_buf_q;
              done_d     = 1'b1;
            end else begin
              crc_err_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    timed = (state_q == WR_REQ) || (state_q == WR_WAIT) ||
            (state_q == RD_REQ) || (state_q == RD_WAIT);
    // A timeout overrides anything decided above, including a CRC error in the same measurement.
    if (timed && tmo_q == TIMEOUT_CYCLES - 20'd1) begin
      timeout_err_d   = 1'b1;
      crc_err_d       = 1'b0;
      crc_error_out_d = 1'b0;
      proc_ready_d    = 1'b0;
      busy_d          = 1'b0;
      done_d          = 1'b0;
      temp_raw_d      = temp_raw_q;
      rh_raw_d        = rh_raw_q;
      state_d         = IDLE;
    end
    tmo_d = (!timed || state_d != state_q) ? 20'd0 : tmo_q + 20'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      crc_err_q       <= 1'b0;
      timeout_err_q   <= 1'b0;
      proc_ready_q    <= 1'b0;
      r_or_w_q        <= 1'b0;
      crc_error_out_q <= 1'b0;
      temp_raw_q      <= '0;
      rh_raw_q        <= '0;
      temp_buf_q      <= '0;
      rh_buf_q        <= '0;
      idx_q           <= '0;
      crc_q           <= '0;
      dly_q           <= '0;
      tmo_q           <= '0;
    end else begin
      state_q         <= state_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      crc_err_q       <= crc_err_d;
      timeout_err_q   <= timeout_err_d;
      proc_ready_q    <= proc_ready_d;
      r_or_w_q        <= r_or_w_d;
      crc_error_out_q <= crc_error_out_d;
      temp_raw_q      <= temp_raw_d;
      rh_raw_q        <= rh_raw_d;
      temp_buf_q      <= temp_buf_d;
      rh_buf_q        <= rh_buf_d;
      idx_q           <= idx_d;
      crc_q           <= crc_d;
      dly_q           <= dly_d;
      tmo_q           <= tmo_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign crc_err       = crc_err_q;
  assign timeout_err   = timeout_err_q;
  assign temp_raw      = temp_raw_q;
  assign rh_raw        = rh_raw_q;
  assign proc_ready    = proc_ready_q;
  assign r_or_w        = r_or_w_q;
  assign crc_error_out = crc_error_out_q;
  assign periph_addr   = DEV_ADDR;
  assign cmd_frame     = MEAS_CMD;
  assign i2c_writes    = 1'b0;
  assign sht_reads     = 4'd5;

endmodule

// File: tb/tb_sht40_measure_sequencer.sv
// Directed bench for sht40_measure_sequencer: hand-driven master handshakes, byte streams and expected words.
module tb_sht40_measure_sequencer;
  localparam int MW = 12;
  localparam int TO = 40;

  logic        clk = 1'b0;
  logic        rst, start, busy, done, crc_err, timeout_err;
  logic [15:0] temp_raw, rh_raw;
  logic        proc_ready, r_or_w, i2c_writes, crc_error_out;
  logic [6:0]  periph_addr;
  logic [7:0]  cmd_frame, rx_data;
  logic [3:0]  sht_reads;
  logic [2:0]  master_state;
  logic        rx_strobe;
  int          tests = 0;
  int          fails = 0;
  int          done_cnt = 0;

  sht40_measure_sequencer #(
    .MEAS_WAIT_CYCLES(20'(MW)),
    .TIMEOUT_CYCLES(20'(TO))
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .crc_err(crc_err), .timeout_err(timeout_err), .temp_raw(temp_raw), .rh_raw(rh_raw),
    .proc_ready(proc_ready), .periph_addr(periph_addr), .cmd_frame(cmd_frame),
    .r_or_w(r_or_w), .i2c_writes(i2c_writes), .sht_reads(sht_reads),
    .crc_error_out(crc_error_out), .master_state(master_state),
    .rx_strobe(rx_strobe), .rx_data(rx_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Master leaves idle while proc_ready is high; the request must drop one cycle later.
  task automatic handshake(input string tag);
    check({tag, "_ready_hi"}, proc_ready, 1);
    master_state = 3'b010;
    tick();
    check({tag, "_ready_drop"}, proc_ready, 0);
  endtask

  // Write phase, then measure the gap from master-idle to the read request:
  // one cycle in WR_WAIT plus MW cycles of conversion wait.
  task automatic write_and_conv(input string tag, input bit extra_start);
    int n;
    handshake({tag, "_wr"});
    if (extra_start) do_start();
    tick();
    master_state = 3'b000;
    n = 0;
    do begin
      tick();
      n++;
    end while (proc_ready !== 1'b1 && n < 200);
    check({tag, "_conv_len"}, n, MW + 1);
    check({tag, "_rd_dir"}, r_or_w, 0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data   = b;
    rx_strobe = 1'b1;
    tick();
    rx_strobe = 1'b0;
    tick();
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; master_state = 3'b000; rx_strobe = 1'b0; rx_data = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_crc_err", crc_err, 0);
    check("rst_tmo_err", timeout_err, 0);
    check("rst_temp", temp_raw, 16'h0000);
    check("rst_rh", rh_raw, 16'h0000);
    check("rst_ready", proc_ready, 0);
    check("const_addr", periph_addr, 7'h44);
    check("const_cmd", cmd_frame, 8'hFD);
    check("const_reads", sht_reads, 4'd5);
    check("const_writes", i2c_writes, 0);

    // Clean measurement, with a start pulse during the write that must be ignored.
    do_start();
    check("m1_busy", busy, 1);
    check("m1_wr_dir", r_or_w, 1);
    write_and_conv("m1", 1'b1);
    handshake("m1_rd");
    send_byte(8'hBE); send_byte(8'hEF); send_byte(8'h92);
    send_byte(8'h66); send_byte(8'h66); send_byte(8'h93);
    check("m1_busy_rd", busy, 1);
    master_state = 3'b000;
    tick();
    check("m1_done", done, 1);
    check("m1_busy_end", busy, 0);
    check("m1_temp", temp_raw, 16'hBEEF);
    check("m1_rh", rh_raw, 16'h6666);
    check("m1_crc_err", crc_err, 0);
    tick();
    check("m1_done_pulse", done, 0);
    check("m1_done_cnt", done_cnt, 1);

    // Bad CRC on the temperature word.
    do_start();
    write_and_conv("m2", 1'b0);
    handshake("m2_rd");
    send_byte(8'hBE); send_byte(8'hEF);
    rx_data = 8'h93; rx_strobe = 1'b1;
    tick();
    rx_strobe = 1'b0;
    check("m2_crc_out", crc_error_out, 1);
    check("m2_crc_err", crc_err, 1);
    tick();
    check("m2_crc_out_pulse", crc_error_out, 0);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    master_state = 3'b000;
    tick();
    check("m2_no_done", done, 0);
    check("m2_busy_end", busy, 0);
    check("m2_temp_kept", temp_raw, 16'hBEEF);
    check("m2_crc_sticky", crc_err, 1);
    tick();
    check("m2_done_cnt", done_cnt, 1);

    // Master hangs in a non-idle state during the write.
    do_start();
    check("m3_crc_cleared", crc_err, 0);
    check("m3_ready", proc_ready, 1);
    master_state = 3'b010;
    n = 0;
    do begin
      tick();
      n++;
    end while (timeout_err !== 1'b1 && n < 300);
    check("m3_tmo_len", n, TO + 1);
    check("m3_tmo_busy", busy, 0);
    check("m3_tmo_ready", proc_ready, 0);
    check("m3_tmo_crc", crc_err, 0);
    master_state = 3'b000;
    tick();
    check("m3_tmo_sticky", timeout_err, 1);

    // Reset in the middle of the read, then a full measurement.
    do_start();
    check("m4_tmo_cleared", timeout_err, 0);
    write_and_conv("m4", 1'b0);
    handshake("m4_rd");
    send_byte(8'hBE); send_byte(8'hEF); send_byte(8'h92);
    rst = 1'b1;
    tick(); tick();
    check("m4_rst_busy", busy, 0);
    check("m4_rst_ready", proc_ready, 0);
    check("m4_rst_temp", temp_raw, 16'h0000);
    check("m4_rst_rh", rh_raw, 16'h0000);
    rst = 1'b0;
    master_state = 3'b000;
    tick();

    do_start();
    write_and_conv("m5", 1'b0);
    handshake("m5_rd");
    send_byte(8'hBE); send_byte(8'hEF); send_byte(8'h92);
    send_byte(8'h66); send_byte(8'h66); send_byte(8'h93);
    master_state = 3'b000;
    tick();
    check("m5_done", done, 1);
    check("m5_temp", temp_raw, 16'hBEEF);
    check("m5_rh", rh_raw, 16'h6666);
    check("m5_crc_err", crc_err, 0);
    repeat (20) tick();
    check("m5_idle_busy", busy, 0);
    check("m5_done_cnt", done_cnt, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sht40_measure_sequencer.md
Name: sht40_measure_sequencer

Overview:
- Sequences the I2C master through one complete SHT40 measurement: command write, conversion wait, 6-byte read, and CRC-8 check of each word.
- Presents the raw temperature and humidity words to the system with done and error flags.
- Sits between the system logic and the I2C master, and drives all of the master's processor-side control inputs.

Parameters:
- DEV_ADDR, 7'h44, SHT40 7-bit address
- MEAS_CMD, 8'hFD, measure command (high precision)
- MEAS_WAIT_CYCLES, 20'd170000, clk cycles between the write completing and the read starting (8.5 ms at 20 MHz)
- TIMEOUT_CYCLES, 20'd100000, maximum cycles allowed in any single master-busy phase

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request for a measurement; ignored unless busy=0
- busy  out  1  high from the accepted start until done or error is asserted
- done  out  1  one-cycle pulse: measurement valid
- crc_err  out  1  sticky until next accepted start: CRC mismatch
- timeout_err  out  1  sticky until next accepted start: a phase exceeded TIMEOUT_CYCLES
- temp_raw  out  16  temperature word (MSB first on bus); updated only on done
- rh_raw  out  16  humidity word; updated only on done
- proc_ready  out  1  to master: start transaction
- periph_addr  out  7  to master: DEV_ADDR, constant
- cmd_frame  out  8  to master: MEAS_CMD
- r_or_w  out  1  to master: 1 = write, 0 = read
- i2c_writes  out  1  to master: 0 (single command byte)
- sht_reads  out  4  to master: 4'd5 (six bytes, zero-based)
- crc_error_out  out  1  to master: abort read
- master_state  in  3  from master: 000 idle, 110 end
- rx_strobe  in  1  from master: one-cycle pulse per received byte
- rx_data  in  8  from master: byte, valid with rx_strobe

Behaviour:
- Reset (any cycle, including mid-transaction):
  - state IDLE; all 1-bit outputs 0; temp_raw = rh_raw = 0.
  - byte index, delay and timeout counters 0.
  - Master is not waited on.
- States: IDLE, WR_REQ, WR_WAIT, CONV, RD_REQ, RD_WAIT, FINISH.
- IDLE:
  - start=1 -> clear crc_err and timeout_err, busy=1, r_or_w=1, go to WR_REQ.
- WR_REQ:
  - proc_ready=1 until master_state != 000, then proc_ready=0 and go to WR_WAIT.
- WR_WAIT:
  - On master_state == 000, go to CONV and clear the delay counter.
- CONV:
  - Count to MEAS_WAIT_CYCLES-1, then r_or_w=0 and go to RD_REQ.
- RD_REQ:
  - Same handshake as WR_REQ, then go to RD_WAIT.
- RD_WAIT:
  - Each rx_strobe stores rx_data at byte index 0..5, and the index increments.
  - Strobes beyond index 5 are ignored.
  - CRC-8 is computed bytewise per word: poly 0x31, init 0xFF, no reflection, no final XOR, over bytes 0-1 and 3-4.
  - Byte 2 is compared to the first result and byte 5 to the second, in the cycle after the strobe.
  - On mismatch: crc_err=1, crc_error_out=1 for exactly one cycle; remaining bytes are ignored.
  - On master_state == 000 (after having left 000), go to FINISH.
- FINISH:
  - If crc_err=0 and 6 bytes were received: temp_raw={b0,b1}, rh_raw={b3,b4}, done pulse.
  - If fewer than 6 bytes arrived with no CRC error: set crc_err.
  - busy=0, return to IDLE.
- Timeout:
  - A counter runs in WR_REQ, WR_WAIT, RD_REQ and RD_WAIT, and clears on each state change.
  - Reaching TIMEOUT_CYCLES sets timeout_err, drops proc_ready, clears busy and returns to IDLE with no done.
- Latency: done is asserted 1 cycle after the master returns to 000 following the read.
- Outputs remain stable between measurements. start while busy=1 is ignored.
- crc_err and timeout_err are never both set by a single measurement; timeout takes priority if they coincide.

Test Plan:
- Read bytes BE EF 92 66 66 93 -> done pulse, temp_raw=16'hBEEF, rh_raw=16'h6666, crc_err=0.
- Read bytes BE EF 93 ... -> crc_error_out pulses 1 cycle after the 3rd strobe, crc_err=1, no done, temp_raw unchanged.
- Master model stays in state 010 forever during write -> timeout_err=1 after TIMEOUT_CYCLES, busy=0, proc_ready=0.
- Verify proc_ready drops the cycle after master_state leaves 000, and the CONV phase lasts exactly MEAS_WAIT_CYCLES clk cycles (measured with small parameter overrides).
- rst asserted during RD_WAIT after 3 bytes, then start -> a full clean measurement completes with correct words.
- start pulsed while busy -> ignored; only one done pulse observed.
